// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MA requester handshakes and the single-port memory bus
// seen by mem_port_arbiter.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdat;

    logic        ma_req;
    logic        ma_wen;
    logic [31:0] ma_addr;
    logic [31:0] ma_wdat;
    logic        ma_gnt;
    logic        ma_rvalid;
    logic [31:0] ma_rdat;

    logic        mem_cs;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;
    logic [31:0] mem_dat_out;

    // Arbiter side: takes requests and memory read data, drives grants and memory controls.
    modport slave (
        input  if_req, if_addr,
        input  ma_req, ma_wen, ma_addr, ma_wdat,
        input  mem_dat_out,
        output if_gnt, if_rvalid, if_rdat,
        output ma_gnt, ma_rvalid, ma_rdat,
        output mem_cs, mem_wen, mem_addr, mem_dat_in
    );

    // Environment side: requesters plus the memory device.
    modport master (
        output if_req, if_addr,
        output ma_req, ma_wen, ma_addr, ma_wdat,
        output mem_dat_out,
        input  if_gnt, if_rvalid, if_rdat,
        input  ma_gnt, ma_rvalid, ma_rdat,
        input  mem_cs, mem_wen, mem_addr, mem_dat_in
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the
// memory-access stage; routes each read's data back to its issuer in order.
module mem_port_arbiter #(
    parameter int RD_LAT        = 1,
    parameter int MAX_MA_STREAK = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int                    STREAK_W   = $clog2(MAX_MA_STREAK + 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_MA_STREAK);
    localparam logic                  ID_IF      = 1'b0;
    localparam logic                  ID_MA      = 1'b1;

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic [RD_LAT-1:0]   tag_vld_q;
    logic [RD_LAT-1:0]   tag_vld_d;
    logic [RD_LAT-1:0]   tag_id_q;
    logic [RD_LAT-1:0]   tag_id_d;

    logic        if_gnt_s;
    logic        ma_gnt_s;
    logic        rd_gnt_s;
    logic        out_vld_s;
    logic        out_id_s;
    logic        if_rvalid_s;
    logic        ma_rvalid_s;
    logic [31:0] mem_addr_s;

    // Arbitration: MA preferred, IF forced in once MA has won MAX_MA_STREAK times in a row.
    always_comb begin
        if_gnt_s = 1'b0;
        ma_gnt_s = 1'b0;
        if (rst_n == 1'b0) begin
            if_gnt_s = 1'b0;
            ma_gnt_s = 1'b0;
        end else if (bus.if_req && bus.ma_req) begin
            if (streak_q == STREAK_MAX) begin
                if_gnt_s = 1'b1;
            end else begin
                ma_gnt_s = 1'b1;
            end
        end else begin
            if_gnt_s = bus.if_req;
            ma_gnt_s = bus.ma_req;
        end
    end

    assign rd_gnt_s = if_gnt_s | (ma_gnt_s & ~bus.ma_wen);

    // Streak counts MA wins only while IF is actually waiting.
    always_comb begin
        streak_d = streak_q;
        if (if_gnt_s || !bus.if_req) begin
            streak_d = '0;
        end else if (ma_gnt_s && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end else begin
            streak_d = streak_q;
        end
    end

    // Read-tag delay line: entry RD_LAT-1 lines up with the memory's read data.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = rd_gnt_s;
        tag_id_d[0]  = ma_gnt_s ? ID_MA : ID_IF;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q  <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            streak_q  <= streak_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Memory address mux; only one grant can be active.
    always_comb begin
        mem_addr_s = 32'h0000_0000;
        if (ma_gnt_s) begin
            mem_addr_s = bus.ma_addr;
        end else if (if_gnt_s) begin
            mem_addr_s = bus.if_addr;
        end else begin
            mem_addr_s = 32'h0000_0000;
        end
    end

    assign out_vld_s   = tag_vld_q[RD_LAT-1];
    assign out_id_s    = tag_id_q[RD_LAT-1];
    assign if_rvalid_s = out_vld_s & (out_id_s == ID_IF);
    assign ma_rvalid_s = out_vld_s & (out_id_s == ID_MA);

    assign bus.if_gnt     = if_gnt_s;
    assign bus.ma_gnt     = ma_gnt_s;
    assign bus.mem_cs     = if_gnt_s | ma_gnt_s;
    assign bus.mem_wen    = ma_gnt_s & bus.ma_wen;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_dat_in = ma_gnt_s ? bus.ma_wdat : 32'h0000_0000;

    assign bus.if_rvalid  = if_rvalid_s;
    assign bus.if_rdat    = if_rvalid_s ? bus.mem_dat_out : 32'h0000_0000;
    assign bus.ma_rvalid  = ma_rvalid_s;
    assign bus.ma_rdat    = ma_rvalid_s ? bus.mem_dat_out : 32'h0000_0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural memory device plus a
// grant/streak model and an in-order response scoreboard.
module tb_mem_port_arbiter;

    localparam int RD_LAT     = 2;
    localparam int MAX_STREAK = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .RD_LAT        (RD_LAT),
        .MAX_MA_STREAK (MAX_STREAK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        if (idx == 8'd64) return 32'hDEAD_BEEF;
        return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
    endfunction

    // Memory device: word array overlaid on a fixed pattern, read data after RD_LAT edges.
    logic [31:0]       dev_mem [0:255];
    logic [255:0]      dev_wr  = '0;
    logic [RD_LAT-1:0] dev_vld = '0;
    logic [31:0]       dev_dat [0:RD_LAT-1];
    logic [31:0]       junk    = 32'h0;

    always @(posedge clk) begin
        junk <= $urandom;
        if (bus.mem_cs && bus.mem_wen) begin
            dev_mem[bus.mem_addr[9:2]] <= bus.mem_dat_in;
            dev_wr[bus.mem_addr[9:2]]  <= 1'b1;
        end
        dev_vld[0] <= bus.mem_cs && !bus.mem_wen;
        dev_dat[0] <= dev_wr[bus.mem_addr[9:2]] ? dev_mem[bus.mem_addr[9:2]]
                                                : init_word(bus.mem_addr[9:2]);
        for (int i = 1; i < RD_LAT; i++) begin
            dev_vld[i] <= dev_vld[i-1];
            dev_dat[i] <= dev_dat[i-1];
        end
    end

    assign bus.mem_dat_out = dev_vld[RD_LAT-1] ? dev_dat[RD_LAT-1] : junk;

    // Reference model state.
    typedef struct {
        logic        id;
        logic [31:0] dat;
        int          due;
    } rsp_t;

    rsp_t         sb[$];
    logic [31:0]  m_mem [0:255];
    logic [255:0] m_wr = '0;
    int           m_streak = 0;
    int           cyc = 0;
    logic         g_if = 1'b0;
    logic         g_ma = 1'b0;
    logic         dut_ma_g = 1'b0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_wr[a[9:2]] ? m_mem[a[9:2]] : init_word(a[9:2]);
    endfunction

    // One clock cycle: drive, check at negedge, advance the model, return just after posedge.
    task automatic step(input logic ir, input logic [31:0] ia, input logic mr,
                        input logic mw, input logic [31:0] mad, input logic [31:0] mwd);
        logic        e_if;
        logic        e_ma;
        logic [31:0] e_addr;
        rsp_t        r;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.ma_req  = mr;
        bus.ma_wen  = mw;
        bus.ma_addr = mad;
        bus.ma_wdat = mwd;
        @(negedge clk);
        e_if   = ir && (!mr || (m_streak == MAX_STREAK));
        e_ma   = mr && !e_if;
        e_addr = e_ma ? mad : (e_if ? ia : 32'h0);
        check_eq("if_gnt",     32'(bus.if_gnt),  32'(e_if));
        check_eq("ma_gnt",     32'(bus.ma_gnt),  32'(e_ma));
        check_eq("mem_cs",     32'(bus.mem_cs),  32'(e_if || e_ma));
        check_eq("mem_wen",    32'(bus.mem_wen), 32'(e_ma && mw));
        check_eq("mem_addr",   bus.mem_addr,     e_addr);
        check_eq("mem_dat_in", bus.mem_dat_in,   (e_ma ? mwd : 32'h0));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            check_eq("if_rvalid", 32'(bus.if_rvalid), 32'(r.id == 1'b0));
            check_eq("ma_rvalid", 32'(bus.ma_rvalid), 32'(r.id == 1'b1));
            check_eq("if_rdat",   bus.if_rdat, (r.id == 1'b0) ? r.dat : 32'h0);
            check_eq("ma_rdat",   bus.ma_rdat, (r.id == 1'b1) ? r.dat : 32'h0);
        end else begin
            check_eq("if_rvalid_idle", 32'(bus.if_rvalid), 32'h0);
            check_eq("ma_rvalid_idle", 32'(bus.ma_rvalid), 32'h0);
            check_eq("if_rdat_idle",   bus.if_rdat, 32'h0);
            check_eq("ma_rdat_idle",   bus.ma_rdat, 32'h0);
        end
        dut_ma_g = bus.ma_gnt;
        if (e_if) begin
            r.id = 1'b0; r.dat = m_read(ia); r.due = cyc + RD_LAT;
            sb.push_back(r);
        end else if (e_ma && !mw) begin
            r.id = 1'b1; r.dat = m_read(mad); r.due = cyc + RD_LAT;
            sb.push_back(r);
        end else if (e_ma && mw) begin
            m_mem[mad[9:2]] = mwd;
            m_wr[mad[9:2]]  = 1'b1;
        end
        if (e_if || !ir) m_streak = 0;
        else if (e_ma && m_streak < MAX_STREAK) m_streak++;
        g_if = e_if;
        g_ma = e_ma;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Asynchronous reset pulse with both requesters pushing; everything must stay quiet.
    task automatic reset_pulse();
        bus.if_req = 1'b1;
        bus.ma_req = 1'b1;
        bus.ma_wen = 1'b0;
        rst_n = 1'b0;
        #2;
        check_eq("rst_if_gnt",    32'(bus.if_gnt),    32'h0);
        check_eq("rst_ma_gnt",    32'(bus.ma_gnt),    32'h0);
        check_eq("rst_mem_cs",    32'(bus.mem_cs),    32'h0);
        check_eq("rst_mem_wen",   32'(bus.mem_wen),   32'h0);
        check_eq("rst_mem_addr",  bus.mem_addr,       32'h0);
        check_eq("rst_dat_in",    bus.mem_dat_in,     32'h0);
        check_eq("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        check_eq("rst_ma_rvalid", 32'(bus.ma_rvalid), 32'h0);
        check_eq("rst_if_rdat",   bus.if_rdat,        32'h0);
        check_eq("rst_ma_rdat",   bus.ma_rdat,        32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_streak = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        if_pend, ma_pend, ma_w;
        logic [31:0] if_a, ma_a, ma_d;
        logic [7:0]  pat;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.ma_req = 1'b1; bus.ma_wen = 1'b0; bus.ma_addr = 32'h0; bus.ma_wdat = 32'h0;
        @(posedge clk);
        #1;
        reset_pulse();

        // MA wins the first contested cycle after reset.
        step(1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        check_eq("first_grant_ma", 32'(dut_ma_g), 32'h1);
        idle(RD_LAT + 1);

        // IF read of the preloaded word.
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(RD_LAT + 1);

        // Streak fairness pattern with both requesters held.
        pat = 8'h00;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'(k * 4), 32'h0);
            pat = {pat[6:0], dut_ma_g};
        end
        check_eq("streak_pattern", 32'(pat), 32'h0000_00EE);
        idle(RD_LAT + 1);

        // Store, then read it back; a store behind an in-flight read.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_1234);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
        idle(RD_LAT + 1);

        // Back-to-back reads IF, MA, IF.
        step(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(RD_LAT + 1);

        // Reset while a read is in flight drops it.
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_pulse();
        idle(RD_LAT + 2);

        // Randomized traffic with holds, drops and occasional resets.
        if_pend = 1'b0; ma_pend = 1'b0; ma_w = 1'b0;
        if_a = 32'h0; ma_a = 32'h0; ma_d = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!if_pend && ($urandom % 4 != 0)) begin
                if_pend = 1'b1;
                if_a = $urandom & 32'hFFFF_FFFC;
            end else if (if_pend && ($urandom % 16 == 0)) begin
                if_pend = 1'b0;
            end
            if (!ma_pend && ($urandom % 3 != 0)) begin
                ma_pend = 1'b1;
                ma_w = ($urandom % 3 == 0);
                ma_a = $urandom & 32'hFFFF_FFFC;
                ma_d = $urandom;
            end else if (ma_pend && ($urandom % 16 == 0)) begin
                ma_pend = 1'b0;
            end
            step(if_pend, if_a, ma_pend, ma_w, ma_a, ma_d);
            if (g_if) if_pend = 1'b0;
            if (g_ma) ma_pend = 1'b0;
            if ($urandom % 400 == 0) reset_pulse();
        end
        idle(RD_LAT + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
